// File: rtl/itr_pkg_fx.sv
// Shared definitions for the prioritised interrupt controller: default sizing,
// derived widths and the lowest-set-bit search used by the priority encoders.
package itr_pkg_fx;

  localparam int NITR_DEF = 4;
  localparam int NEST_DEF = 2;
  localparam int IDW      = (NITR_DEF > 1) ? $clog2(NITR_DEF) : 1;
  localparam int DPW      = $clog2(NEST_DEF + 1);

  // Widest vector lsb_idx can search; encoders zero-extend into this.
  localparam int LSB_MAXW = 32;

  function automatic int lsb_idx(input logic [LSB_MAXW-1:0] vec);
    int r;
    r = 0;
    for (int i = LSB_MAXW - 1; i >= 0; i--) begin
      if (vec[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_fx.sv
// Fixed-priority encoder: index 0 wins. Pure combinational, idx_o is 0 when
// nothing is set.
module prio_enc_fx
  import itr_pkg_fx::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic         vld_o,
  output logic [W-1:0] idx_o
);

  logic [LSB_MAXW-1:0] vec_ext;

  assign vec_ext = LSB_MAXW'(vec_i);
  assign vld_o   = |vec_i;
  assign idx_o   = W'(lsb_idx(vec_ext));

endmodule

// File: rtl/itr_ctrl_fx.sv
// Nesting, maskable, fixed-priority interrupt controller in front of the core's
// single interrupt input. All outputs are decoded from registered state only.
module itr_ctrl_fx
  import itr_pkg_fx::*;
#(
  parameter int NITR   = NITR_DEF,
  parameter int MINSTW = 9,
  parameter int VBASE  = 1,
  parameter int VSTEP  = 4,
  parameter int NEST   = NEST_DEF,
  parameter int EDGE   = 1,
  localparam int IW    = (NITR > 1) ? $clog2(NITR) : 1,
  localparam int DW    = $clog2(NEST + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NITR-1:0]   irq_in,
  input  logic              cfg_wr,
  input  logic [NITR-1:0]   cfg_data,
  input  logic              itr_ack,
  input  logic              reti,
  output logic              itr,
  output logic [MINSTW-1:0] itr_addr,
  output logic [IW-1:0]     itr_id,
  output logic [DW-1:0]     depth,
  output logic              err
);

  localparam logic [DW-1:0] NEST_W = DW'(NEST);

  logic [NITR-1:0] irq_prev_q, irq_prev_d;
  logic [NITR-1:0] pend_q, pend_d;
  logic [NITR-1:0] mask_q, mask_d;
  logic [NITR-1:0] isr_q, isr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;

  logic [NITR-1:0] cap;
  logic [NITR-1:0] allow;
  logic [NITR-1:0] elig;
  logic [NITR-1:0] pend_clr;
  logic            isr_vld;
  logic [IW-1:0]   isr_top;
  logic            req_vld;
  logic [IW-1:0]   req_id;
  logic            itr_int;

  prio_enc_fx #(.N(NITR), .W(IW)) u_isr_enc (
    .vec_i (isr_q),
    .vld_o (isr_vld),
    .idx_o (isr_top)
  );

  // Only sources strictly more urgent than the most urgent running ISR may preempt.
  always_comb begin
    allow = '0;
    for (int i = 0; i < NITR; i++) begin
      allow[i] = ~isr_vld | (IW'(i) < isr_top);
    end
  end

  assign elig = pend_q & mask_q & allow;

  prio_enc_fx #(.N(NITR), .W(IW)) u_elig_enc (
    .vec_i (elig),
    .vld_o (req_vld),
    .idx_o (req_id)
  );

  assign itr_int  = req_vld && (depth_q < NEST_W);
  assign itr      = itr_int;
  assign itr_id   = itr_int ? req_id : '0;
  assign itr_addr = itr_int ? MINSTW'(VBASE + int'(req_id) * VSTEP) : '0;
  assign depth    = depth_q;
  assign err      = err_q;

  assign cap = (EDGE != 0) ? (irq_in & ~irq_prev_q) : irq_in;

  // reti is applied before the ack so a same-cycle pair leaves depth unchanged.
  always_comb begin
    isr_d      = isr_q;
    depth_d    = depth_q;
    err_d      = err_q;
    pend_clr   = '0;
    irq_prev_d = irq_in;
    mask_d     = cfg_wr ? cfg_data : mask_q;

    if (reti) begin
      if (depth_q == '0) begin
        err_d = 1'b1;
      end else begin
        isr_d[isr_top] = 1'b0;
        depth_d        = depth_d - DW'(1);
      end
    end

    if (itr_ack) begin
      if (itr_int) begin
        pend_clr[req_id] = 1'b1;
        isr_d[req_id]    = 1'b1;
        depth_d          = depth_d + DW'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    // A fresh capture on the acked source survives the clear.
    pend_d = (pend_q & ~pend_clr) | cap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '1;
      isr_q      <= '0;
      depth_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      isr_q      <= isr_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
    end
  end

  a_depth_matches_isr : assert property (@(posedge clk) disable iff (rst)
    int'(depth_q) == $countones(isr_q));

  a_depth_bounded : assert property (@(posedge clk) disable iff (rst)
    depth_q <= NEST_W);

endmodule

// File: tb/tb_itr_ctrl_fx.sv
// Bench for itr_ctrl_fx: directed tables on an edge and a level instance, then
// randomized traffic against a behavioural model of the priority/nesting rules.
module tb_itr_ctrl_fx;

  localparam int NEST = 2;

  typedef struct {
    int irq; int cw; int cd; int ack; int reti; int rst;
    int e_itr; int e_id; int e_addr; int e_depth; int e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic [3:0] irq_s  [2];
  logic       cw_s   [2];
  logic [3:0] cd_s   [2];
  logic       ack_s  [2];
  logic       reti_s [2];
  logic       rst_s  [2];
  logic       itr_s  [2];
  logic [8:0] addr_s [2];
  logic [1:0] id_s   [2];
  logic [1:0] depth_s[2];
  logic       err_s  [2];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_pend[2], m_mask[2], m_isr[2], m_prev[2];
  logic       m_err[2];

  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  itr_ctrl_fx #(.EDGE(1)) u_a (
    .clk(clk), .rst(rst_s[0]), .irq_in(irq_s[0]), .cfg_wr(cw_s[0]), .cfg_data(cd_s[0]),
    .itr_ack(ack_s[0]), .reti(reti_s[0]), .itr(itr_s[0]), .itr_addr(addr_s[0]),
    .itr_id(id_s[0]), .depth(depth_s[0]), .err(err_s[0])
  );

  itr_ctrl_fx #(.EDGE(0)) u_b (
    .clk(clk), .rst(rst_s[1]), .irq_in(irq_s[1]), .cfg_wr(cw_s[1]), .cfg_data(cd_s[1]),
    .itr_ack(ack_s[1]), .reti(reti_s[1]), .itr(itr_s[1]), .itr_addr(addr_s[1]),
    .itr_id(id_s[1]), .depth(depth_s[1]), .err(err_s[1])
  );

  function automatic vec_t mk(int irq, int cw, int cd, int ack, int reti, int rst,
                              int e_itr, int e_id, int e_addr, int e_depth, int e_err);
    vec_t v;
    v.irq = irq; v.cw = cw; v.cd = cd; v.ack = ack; v.reti = reti; v.rst = rst;
    v.e_itr = e_itr; v.e_id = e_id; v.e_addr = e_addr; v.e_depth = e_depth; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int k, input int irq, input int cw, input int cd,
                       input int ack, input int reti, input int rst);
    irq_s[k]  = 4'(irq);
    cw_s[k]   = (cw != 0);
    cd_s[k]   = 4'(cd);
    ack_s[k]  = (ack != 0);
    reti_s[k] = (reti != 0);
    rst_s[k]  = (rst != 0);
  endtask

  task automatic check_outs(input string tag, input int k, input int e_itr, input int e_id,
                            input int e_addr, input int e_depth, input int e_err);
    check($sformatf("%s.itr", tag),   int'(itr_s[k]),   e_itr);
    check($sformatf("%s.id", tag),    int'(id_s[k]),    e_id);
    check($sformatf("%s.addr", tag),  int'(addr_s[k]),  e_addr);
    check($sformatf("%s.depth", tag), int'(depth_s[k]), e_depth);
    check($sformatf("%s.err", tag),   int'(err_s[k]),   e_err);
  endtask

  task automatic apply_row(input int k, input vec_t v, input string tag);
    drive(k, v.irq, v.cw, v.cd, v.ack, v.reti, v.rst);
    @(posedge clk);
    #1;
    check_outs(tag, k, v.e_itr, v.e_id, v.e_addr, v.e_depth, v.e_err);
  endtask

  // Request the rules allow: most urgent pending+enabled source that no running
  // ISR of equal or greater urgency blocks, provided nesting room remains.
  function automatic int m_req(int k);
    if ($countones(m_isr[k]) >= NEST) return -1;
    for (int i = 0; i < 4; i++) begin
      if (m_pend[k][i] && m_mask[k][i]) begin
        bit blocked = 1'b0;
        for (int j = 0; j <= i; j++) if (m_isr[k][j]) blocked = 1'b1;
        if (!blocked) return i;
      end
    end
    return -1;
  endfunction

  task automatic m_step(input int k);
    int r;
    logic [3:0] cap;
    r = m_req(k);
    if (rst_s[k]) begin
      m_pend[k] = '0; m_mask[k] = '1; m_isr[k] = '0; m_prev[k] = '0; m_err[k] = 1'b0;
      return;
    end
    cap = (k == 0) ? (irq_s[k] & ~m_prev[k]) : irq_s[k];
    if (reti_s[k]) begin
      if (m_isr[k] == '0) m_err[k] = 1'b1;
      else begin
        for (int i = 0; i < 4; i++) begin
          if (m_isr[k][i]) begin
            m_isr[k][i] = 1'b0;
            break;
          end
        end
      end
    end
    if (ack_s[k]) begin
      if (r >= 0) begin
        m_pend[k][r] = 1'b0;
        m_isr[k][r]  = 1'b1;
      end else m_err[k] = 1'b1;
    end
    m_pend[k] = m_pend[k] | cap;
    if (cw_s[k]) m_mask[k] = cd_s[k];
    m_prev[k] = irq_s[k];
  endtask

  initial begin
    // irq, cw, cd, ack, reti, rst | itr, id, addr, depth, err
    tab_a.push_back(mk('b0100, 0, 0, 0, 0, 0,  1, 2,  9, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk('b1000, 0, 0, 0, 0, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk('b0001, 0, 0, 0, 0, 0,  1, 0,  1, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk('b0001, 0, 0, 0, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  1, 0,  1, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  1, 3, 13, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk('b0010, 0, 0, 0, 0, 0,  1, 1,  5, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk('b0001, 0, 0, 0, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  1, 0,  1, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 2, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 0));
    tab_a.push_back(mk(0,      1, 'b1011, 0, 0, 0,  0, 0, 0, 0, 0));
    tab_a.push_back(mk('b0100, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 0, 0,  0, 0,  0, 0, 0));
    tab_a.push_back(mk(0,      1, 'b1111, 0, 0, 0,  1, 2, 9, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 1));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 0, 1));
    tab_a.push_back(mk('b1000, 0, 0, 0, 0, 0,  1, 3, 13, 0, 1));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 1));
    tab_a.push_back(mk('b0010, 0, 0, 0, 0, 0,  1, 1,  5, 1, 1));
    tab_a.push_back(mk(0,      0, 0, 1, 1, 0,  0, 0,  0, 1, 1));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 1));
    tab_a.push_back(mk('b0001, 0, 0, 0, 0, 0,  1, 0,  1, 0, 1));
    tab_a.push_back(mk(0,      0, 0, 0, 0, 0,  1, 0,  1, 0, 1));
    tab_a.push_back(mk('b0001, 0, 0, 1, 0, 0,  0, 0,  0, 1, 1));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  1, 0,  1, 0, 1));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 1));
    tab_a.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 1));
    tab_a.push_back(mk(0,      0, 0, 0, 0, 1,  0, 0,  0, 0, 0));
    tab_a.push_back(mk('b0100, 0, 0, 0, 0, 0,  1, 2,  9, 0, 0));
    tab_a.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_a.push_back(mk(0,      0, 0, 0, 0, 1,  0, 0,  0, 0, 0));

    tab_b.push_back(mk('b0010, 0, 0, 0, 0, 0,  1, 1,  5, 0, 0));
    tab_b.push_back(mk('b0010, 0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_b.push_back(mk('b0010, 0, 0, 0, 1, 0,  1, 1,  5, 0, 0));
    tab_b.push_back(mk('b0010, 0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_b.push_back(mk('b0011, 0, 0, 0, 0, 0,  1, 0,  1, 1, 0));
    tab_b.push_back(mk('b0011, 0, 0, 1, 1, 0,  0, 0,  0, 1, 0));
    tab_b.push_back(mk(0,      0, 0, 0, 1, 0,  1, 0,  1, 0, 0));
    tab_b.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_b.push_back(mk(0,      0, 0, 0, 1, 0,  1, 1,  5, 0, 0));
    tab_b.push_back(mk(0,      0, 0, 1, 0, 0,  0, 0,  0, 1, 0));
    tab_b.push_back(mk(0,      0, 0, 0, 1, 0,  0, 0,  0, 0, 0));

    for (int k = 0; k < 2; k++) drive(k, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset_a", 0, 0, 0, 0, 0, 0);
    check_outs("reset_b", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) drive(k, 0, 0, 0, 0, 0, 0);

    foreach (tab_a[i]) apply_row(0, tab_a[i], $sformatf("edge[%0d]", i));
    drive(0, 0, 0, 0, 0, 0, 0);
    foreach (tab_b[i]) apply_row(1, tab_b[i], $sformatf("level[%0d]", i));
    drive(1, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 2; k++) drive(k, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_step(k);
    #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        int irq;
        r = m_req(k);
        irq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15) & $urandom_range(0, 15))
                                           : ((k == 1) ? int'(irq_s[k]) : 0);
        drive(k, irq,
              ($urandom_range(0, 29) == 0) ? 1 : 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 'b1111,
              (r >= 0) ? int'($urandom_range(0, 1)) : (($urandom_range(0, 40) == 0) ? 1 : 0),
              ($countones(m_isr[k]) > 0) ? (($urandom_range(0, 3) == 0) ? 1 : 0)
                                         : (($urandom_range(0, 60) == 0) ? 1 : 0),
              ($urandom_range(0, 299) == 0) ? 1 : 0);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) m_step(k);
      #1;
      for (int k = 0; k < 2; k++) begin
        int r;
        r = m_req(k);
        check_outs($sformatf("rnd%0d[%0d]", k, cyc), k,
                   (r >= 0) ? 1 : 0, (r >= 0) ? r : 0, (r >= 0) ? (1 + 4 * r) : 0,
                   $countones(m_isr[k]), int'(m_err[k]));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
